tank_pump_controller: RTL and testbench

Sequential controller that drives the fill pump for the water tank whose 8-probe level sensor feeds the tank level indicator. It debounces the raw probe vector, converts it to a level count, and runs a fill/hold state machine with hysteresis between a low and a high mark. It also detects a dry-run (pump on, no level progress) and incoherent sensor patterns, latching an alarm until operator clear. It sits between the level sensor inputs and the pump relay driver.

---
 rtl/tank_pkg.sv | 31 +++
 rtl/probe_debounce.sv | 66 ++++++
 rtl/tank_pump_controller.sv | 89 ++++++++
 tb/tb_tank_pump_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types for the tank pump controller: FSM state encoding, probe count
// and level/coherence helpers for the 8-probe level sensor.
package tank_pkg;

    localparam int TANK_PROBES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } tank_state_t;

    // Level is the index of the highest wet probe plus one, 0 when all dry.
    function automatic logic [3:0] probe_level(input logic [TANK_PROBES-1:0] v);
        logic [3:0] l;
        l = 4'd0;
        for (int i = 0; i < TANK_PROBES; i++) begin
            if (v[i]) l = 4'(i + 1);
        end
        return l;
    endfunction

    // A coherent vector is thermometer coded: adding one clears every set bit.
    function automatic logic probe_coherent(input logic [TANK_PROBES-1:0] v);
        logic [TANK_PROBES:0] ext;
        ext = {1'b0, v};
        return (ext & (ext + 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/probe_debounce.sv
// Debounces the raw probe vector and derives level, level_valid and a
// level-increase strobe; the coherence check is built only with TANK_SENSOR_CHECK_EN.
module probe_debounce
    import tank_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TANK_PROBES-1:0] water_i,
    output logic [3:0]             level_o,
    output logic                   level_valid_o,
    output logic                   level_up_o,
    output logic                   sensor_fault_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [TANK_PROBES-1:0] cand_q, cand_d;
    logic [TANK_PROBES-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;

    // The counter saturates at CNT_MAX, so a stable input is re-accepted each cycle.
    always_comb begin
        cand_d     = water_i;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        valid_d    = valid_q;
        level_up_o = 1'b0;
        if (water_i != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            acc_d      = cand_q;
            valid_d    = 1'b1;
            level_up_o = probe_level(cand_q) > probe_level(acc_q);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign level_o       = probe_level(acc_q);
    assign level_valid_o = valid_q;

`ifdef TANK_SENSOR_CHECK_EN
    assign sensor_fault_o = !probe_coherent(acc_q);
`else
    assign sensor_fault_o = 1'b0;
`endif

endmodule

// File: rtl/tank_pump_controller.sv
// Fill/hold pump controller with hysteresis, dry-run timeout and latched alarm.
// Sensor coherence faults exist only when TANK_SENSOR_CHECK_EN is defined.
module tank_pump_controller
    import tank_pkg::*;
#(
    parameter int DEBOUNCE     = 4,
    parameter int LOW_MARK     = 2,
    parameter int HIGH_MARK    = 7,
    parameter int FILL_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fault_clear,
    input  logic [TANK_PROBES-1:0] water,
    output logic                   pump_on,
    output logic                   alarm,
    output logic [3:0]             level,
    output logic                   level_valid,
    output logic [1:0]             state
);

    localparam int TIMER_W = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [3:0] LOW_LVL  = 4'(LOW_MARK);
    localparam logic [3:0] HIGH_LVL = 4'(HIGH_MARK);

    tank_state_t        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               level_up;
    logic               sensor_fault;
    logic               timeout;

    probe_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .water_i        (water),
        .level_o        (level),
        .level_valid_o  (level_valid),
        .level_up_o     (level_up),
        .sensor_fault_o (sensor_fault)
    );

    assign timeout = (timer_q == TIMER_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (sensor_fault)                state_d = FAULT;
                else if (enable && level_valid)  state_d = (level > LOW_LVL) ? HOLD : FILL;
            end
            FILL: begin
                if (sensor_fault || timeout)     state_d = FAULT;
                else if (!enable)                state_d = IDLE;
                else if (level >= HIGH_LVL)      state_d = HOLD;
            end
            HOLD: begin
                if (sensor_fault)                state_d = FAULT;
                else if (!enable)                state_d = IDLE;
                else if (level <= LOW_LVL)       state_d = FILL;
            end
            FAULT: begin
                if (fault_clear && !sensor_fault) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Progress timer: only a level rise counts as progress, falls do not.
        if (state_q == FILL) timer_d = level_up ? '0 : timer_q + 1'b1;
        if (state_d == FILL && state_q != FILL) timer_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign pump_on = (state_q == FILL);
    assign alarm   = (state_q == FAULT);
    assign state   = state_q;

endmodule

// File: tb/tb_tank_pump_controller.sv
// Randomized scoreboard bench for tank_pump_controller against a window-based
// behavioural model; honours TANK_SENSOR_CHECK_EN when defined.
module tb_tank_pump_controller;

    localparam int D_CYC  = 4;
    localparam int LOW_M  = 2;
    localparam int HIGH_M = 7;
    localparam int TMO    = 20;
`ifdef TANK_SENSOR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fault_clear = 1'b0;
    logic [7:0] water = 8'h00;
    logic       pump_on;
    logic       alarm;
    logic [3:0] level;
    logic       level_valid;
    logic [1:0] state;

    tank_pump_controller #(
        .DEBOUNCE(D_CYC), .LOW_MARK(LOW_M), .HIGH_MARK(HIGH_M), .FILL_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault_clear(fault_clear),
        .water(water), .pump_on(pump_on), .alarm(alarm), .level(level),
        .level_valid(level_valid), .state(state)
    );

    always #5 clk = ~clk;

    // Expected outputs after each edge: {state, pump, alarm, level, valid}.
    logic [8:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: samples seen since reset (reset counts as one sample of 0).
    logic [7:0] hist[$];
    int         m_state = 0;
    int         m_level = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_vec   = 8'h00;
    int         m_stall = 0;

    function automatic int lvl_of(input logic [7:0] v);
        int l;
        l = 0;
        for (int i = 0; i < 8; i++) if (v[i]) l = i + 1;
        return l;
    endfunction

    function automatic bit thermo(input logic [7:0] v);
        logic [8:0] t;
        for (int n = 0; n <= 8; n++) begin
            t = (9'd1 << n) - 9'd1;
            if ({1'b0, v} == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input bit r, input bit en, input bit fc, input logic [7:0] w);
        bit sf, acc, progress, same;
        int ns, nl;
        if (r) begin
            m_state = 0; m_level = 0; m_valid = 0; m_vec = 8'h00; m_stall = 0;
            hist.delete();
            hist.push_back(8'h00);
            return;
        end
        sf = CHECK && !thermo(m_vec);
        ns = m_state;
        case (m_state)
            0: if (sf) ns = 3; else if (en && m_valid) ns = (m_level > LOW_M) ? 2 : 1;
            1: if (sf || m_stall >= TMO - 1) ns = 3; else if (!en) ns = 0;
               else if (m_level >= HIGH_M) ns = 2;
            2: if (sf) ns = 3; else if (!en) ns = 0; else if (m_level <= LOW_M) ns = 1;
            default: if (fc && !sf) ns = 0;
        endcase
        // Accept once the last DEBOUNCE+1 samples agree.
        hist.push_back(w);
        if (hist.size() > D_CYC + 1) void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != w) same = 1'b0;
        acc = (hist.size() == D_CYC + 1) && same;
        nl = acc ? lvl_of(w) : m_level;
        progress = acc && (nl > m_level);
        if (ns == 1 && m_state != 1)  m_stall = 0;
        else if (m_state == 1)        m_stall = progress ? 0 : m_stall + 1;
        if (acc) begin
            m_vec = w;
            m_valid = 1'b1;
        end
        m_level = nl;
        m_state = ns;
    endtask

    task automatic tick(input bit r, input bit en, input bit fc, input logic [7:0] w);
        logic [8:0] e;
        @(negedge clk);
        rst = r; enable = en; fault_clear = fc; water = w;
        model_edge(r, en, fc, w);
        e = {2'(m_state), m_state == 1, m_state == 3, 4'(m_level), m_valid};
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic hold(input int n, input bit en, input bit fc, input logic [7:0] w);
        for (int i = 0; i < n; i++) tick(1'b0, en, fc, w);
    endtask

    // Monitor: one output word per edge, compared just after the edge.
    initial begin
        logic [8:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {state, pump_on, alarm, level, level_valid};
                checks++;
                if (g !== e)
                    $display("FAIL outputs cycle %0d: got state=%0d pump=%0b alarm=%0b level=%0d valid=%0b, expected state=%0d pump=%0b alarm=%0b level=%0d valid=%0b",
                             cyc, g[8:7], g[6], g[5], g[4:1], g[0], e[8:7], e[6], e[5], e[4:1], e[0]);
                else
                    passed++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] tv;
        logic [7:0] w;
        bit en, fc, r;
        hist.push_back(8'h00);
        // Reset, then dry tank with enable: valid after 4 edges, FILL next.
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        hold(6, 1'b1, 1'b0, 8'h00);
        // Ramp to level 7 -> HOLD, drop to level 2 -> FILL.
        for (int l = 1; l <= 7; l++) begin
            tv = (9'd1 << l) - 9'd1;
            hold(10, 1'b1, 1'b0, tv[7:0]);
        end
        hold(10, 1'b1, 1'b0, 8'h03);
        // Short glitch never reaches the level.
        hold(8, 1'b1, 1'b0, 8'h07);
        hold(3, 1'b1, 1'b0, 8'hFF);
        hold(8, 1'b1, 1'b0, 8'h07);
        // Frozen low level in FILL: dry-run timeout, then clear and refill.
        hold(30, 1'b1, 1'b0, 8'h01);
        hold(1, 1'b1, 1'b1, 8'h01);
        hold(5, 1'b1, 1'b0, 8'h01);
        // Enable drop with a fresh timeout race.
        hold(22, 1'b1, 1'b0, 8'h01);
        hold(2, 1'b0, 1'b1, 8'h01);
        // Incoherent vector, clear held, then coherent vector.
        hold(10, 1'b1, 1'b0, 8'h11);
        hold(5, 1'b1, 1'b1, 8'h11);
        hold(10, 1'b1, 1'b1, 8'h1F);
        hold(4, 1'b1, 1'b0, 8'h1F);
        // Reset mid-FILL at level 5.
        hold(10, 1'b1, 1'b1, 8'h03);
        hold(10, 1'b1, 1'b0, 8'h1F);
        tick(1'b1, 1'b1, 1'b0, 8'h1F);
        hold(8, 1'b1, 1'b0, 8'h1F);
        // Random segments.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                w = 8'($urandom);
            end else begin
                tv = (9'd1 << $urandom_range(0, 8)) - 9'd1;
                w = tv[7:0];
            end
            en = ($urandom_range(0, 15) != 0);
            fc = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 39) == 0);
            if (r) tick(1'b1, en, fc, w);
            hold($urandom_range(1, 12), en, fc, w);
            if ($urandom_range(0, 5) == 0) hold(TMO + 2, 1'b1, 1'b0, w);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
